// File: rtl/mul_seq.sv
// Sequential 16x16->32 unsigned shift-add multiplier that borrows an external ALU
// for every addition; one product every 18 cycles at best.
module mul_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [3:0]  alu_select,
    input  logic [15:0] alu_agg,
    input  logic        alu_c,
    output logic        busy,
    output logic        done,
    output logic [15:0] prod_hi,
    output logic [15:0] prod_lo,
    output logic        prod_v,
    output logic        prod_z
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] SEL_ADD  = 4'h4;
    localparam logic [3:0] SEL_NONE = 4'h0;

    logic [1:0]  state_reg;
    logic [15:0] acc_reg;
    logic [15:0] mq_reg;
    logic [15:0] mcand_reg;
    logic [3:0]  count_reg;
    logic [15:0] prod_hi_reg;
    logic [15:0] prod_lo_reg;
    logic        prod_v_reg;
    logic        prod_z_reg;

    logic [15:0] acc_next;
    logic [15:0] mq_next;

    // One shift-add step: when the multiplier LSB is set, the ALU sum (with its
    // carry as bit 16) replaces acc before the right shift of {acc, mq}.
    always_comb begin
        acc_next = {1'b0, acc_reg[15:1]};
        mq_next  = {acc_reg[0], mq_reg[15:1]};
        if (mq_reg[0]) begin
            acc_next = {alu_c, alu_agg[15:1]};
            mq_next  = {alu_agg[0], mq_reg[15:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            acc_reg     <= 16'h0000;
            mq_reg      <= 16'h0000;
            mcand_reg   <= 16'h0000;
            count_reg   <= 4'd0;
            prod_hi_reg <= 16'h0000;
            prod_lo_reg <= 16'h0000;
            prod_v_reg  <= 1'b0;
            prod_z_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        mcand_reg <= op_a;
                        mq_reg    <= op_b;
                        acc_reg   <= 16'h0000;
                        count_reg <= 4'd0;
                        state_reg <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc_reg <= acc_next;
                    mq_reg  <= mq_next;
                    if (count_reg == 4'd15) begin
                        // Last iteration: capture the finished product directly.
                        prod_hi_reg <= acc_next;
                        prod_lo_reg <= mq_next;
                        prod_v_reg  <= (acc_next != 16'h0000);
                        prod_z_reg  <= ({acc_next, mq_next} == 32'h0000_0000);
                        state_reg   <= ST_DONE;
                    end else begin
                        count_reg <= count_reg + 4'd1;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign alu_a      = (state_reg == ST_RUN) ? acc_reg   : 16'h0000;
    assign alu_b      = (state_reg == ST_RUN) ? mcand_reg : 16'h0000;
    assign alu_select = (state_reg == ST_RUN) ? SEL_ADD   : SEL_NONE;

    assign busy    = (state_reg != ST_IDLE);
    assign done    = (state_reg == ST_DONE);
    assign prod_hi = prod_hi_reg;
    assign prod_lo = prod_lo_reg;
    assign prod_v  = prod_v_reg;
    assign prod_z  = prod_z_reg;

endmodule

// File: doc/mul_seq.md
MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 The block SHALL have no parameters; all datapath widths are fixed at 16 bits.
REQ-002 The block SHALL have these ports, listed as name, direction, width and meaning:
- clk, input, 1: the single clock; all state updates on its rising edge.
- reset, input, 1: synchronous, active-high reset.
- start, input, 1: request to begin a multiply; sampled only in IDLE.
- op_a, input, 16: multiplicand; captured on accepted start.
- op_b, input, 16: multiplier; captured on accepted start.
- alu_a, output, 16: ALU A operand.
- alu_b, output, 16: ALU B operand.
- alu_select, output, 4: ALU select code.
- alu_agg, input, 16: ALU result.
- alu_c, input, 1: ALU carry-out.
- busy, output, 1: high whenever state is not IDLE.
- done, output, 1: one-cycle pulse when the product is valid.
- prod_hi, output, 16: upper product half, registered.
- prod_lo, output, 16: lower product half, registered.
- prod_v, output, 1: high when prod_hi is non-zero (16-bit unsigned overflow), registered.
- prod_z, output, 1: high when the full 32-bit product is zero, registered.

Function
REQ-003 The block SHALL compute the unsigned 16x16->32 product op_a*op_b by shift-add over 16 iterations. Every addition SHALL be performed by the external ALU; the block SHALL contain no adder of its own.
REQ-004 The state machine SHALL have three states: IDLE, RUN and DONE.
- IDLE->RUN on start=1.
- RUN->DONE after the 16th iteration.
- DONE->IDLE unconditionally after one cycle.
REQ-005 On accepted start, the block SHALL load:
- mcand=op_a
- mq=op_b
- acc=16'h0000
- iteration count=0
REQ-006 In RUN, the ALU drive SHALL be: alu_a=acc, alu_b=mcand, alu_select=4'h4 (ADD with the override bit clear).
REQ-007 Outside RUN, the ALU drive SHALL be: alu_a=16'h0000, alu_b=16'h0000, alu_select=4'h0.
REQ-008 Each RUN cycle, if mq[0]=1, the 33-bit value {alu_c, alu_agg, mq} SHALL be shifted right by one into {acc, mq}.
REQ-009 Each RUN cycle, if mq[0]=0, the 33-bit value {1'b0, acc, mq} SHALL be shifted right by one into {acc, mq}.
REQ-010 The iteration count SHALL increment each RUN cycle. The transition to DONE SHALL occur when count=15 is processed; the count SHALL NOT wrap in RUN.
REQ-011 On the RUN->DONE edge, the block SHALL register:
- prod_hi=final acc
- prod_lo=final mq
- prod_v=(final acc!=0)
- prod_z=({acc,mq}==0)
REQ-012 done SHALL be 1 only during the DONE cycle.
REQ-013 prod_* SHALL hold their values until the next RUN->DONE edge or reset; they SHALL remain stable through the next operation.
REQ-014 Latency: with start sampled at edge N, RUN SHALL occupy cycles N+1..N+16, and done=1 during cycle N+17. busy SHALL be 1 during cycles N+1..N+17.
REQ-015 start SHALL be ignored in RUN and DONE; op_a and op_b SHALL be ignored except on an accepted start.
REQ-016 Back-to-back operation: a start asserted in the cycle after DONE SHALL be accepted. Minimum issue interval is 18 cycles.
REQ-017 If reset and start are both high at the same edge, reset SHALL win; state SHALL become IDLE and start SHALL be discarded.
REQ-018 alu_c SHALL be consumed only in RUN cycles with mq[0]=1; alu_agg and alu_c SHALL be ignored otherwise.

Reset
REQ-019 On reset=1 at a clock edge, regardless of state (including mid-RUN), the block SHALL go to IDLE and clear:
- acc, mq, mcand and the count to 0
- prod_hi and prod_lo to 16'h0000
- prod_v=0, prod_z=0
- busy=0, done=0
REQ-020 The ALU drive after reset SHALL be alu_a=0, alu_b=0, alu_select=4'h0.
REQ-021 There SHALL be no asynchronous reset path. Outputs SHALL be undefined before the first reset edge only.

Verification
REQ-022 Basic multiply: start at edge 0 with op_a=16'h0003, op_b=16'h0005 -> busy cycles 1-17, done=1 only in cycle 17, prod_hi=16'h0000, prod_lo=16'h000F, prod_v=0, prod_z=0.
REQ-023 Maximum operands: op_a=op_b=16'hFFFF -> prod_hi=16'hFFFE, prod_lo=16'h0001, prod_v=1, prod_z=0; alu_c=1 is observed and consumed in at least one RUN cycle.
REQ-024 Zero operand and ALU drive: op_a=16'h1234, op_b=16'h0000 -> prod_hi=prod_lo=0, prod_z=1, prod_v=0; alu_select=4'h4 in every RUN cycle and 4'h0 otherwise.
REQ-025 Start while busy: start=1 held through cycles 0-17 with op_a/op_b changed at cycle 5 -> the result reflects the cycle-0 operands only; a second accept occurs at the cycle-18 edge; done pulses exactly once per accept.
REQ-026 Reset mid-operation: reset=1 at cycle 8 of RUN after a prior 16'h0002*16'h0003 result -> next cycle busy=0, done=0, prod_lo=16'h0000, and no done pulse follows.
REQ-027 Simultaneous reset and start: reset=1 and start=1 on the same edge -> IDLE, busy=0 next cycle; start on the following edge is accepted normally.
